// File: rtl/ddr3_avl_arbiter_if.sv
// ddr3_avl_arbiter_if
// Bundles the Avalon-MM command/response signals of NUM_PORTS agents.
// The upstream instance carries all requesting masters, with master i in
// slice i. The downstream instance, with NUM_PORTS = 1, carries the single
// DDR3 slave port.
//   address       : NUM_PORTS*ADDR_WIDTH   word address
//   writedata     : NUM_PORTS*DATA_WIDTH   write data
//   byteenable    : NUM_PORTS*BYTE_EN_WIDTH byte enables
//   write / read  : NUM_PORTS              command strobes
//   waitrequest   : NUM_PORTS              command stall, per port
//   readdata      : DATA_WIDTH             read data, shared by all ports
//   readdatavalid : NUM_PORTS              read-data-valid, per port
// The master modport is the command issuer; the slave modport is the
// command acceptor.
interface ddr3_avl_arbiter_if #(
  parameter int NUM_PORTS     = 1,
  parameter int ADDR_WIDTH    = 29,
  parameter int DATA_WIDTH    = 512,
  parameter int BYTE_EN_WIDTH = DATA_WIDTH / 8
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0]    address;
  logic [NUM_PORTS*DATA_WIDTH-1:0]    writedata;
  logic [NUM_PORTS*BYTE_EN_WIDTH-1:0] byteenable;
  logic [NUM_PORTS-1:0]               write;
  logic [NUM_PORTS-1:0]               read;
  logic [NUM_PORTS-1:0]               waitrequest;
  logic [DATA_WIDTH-1:0]              readdata;
  logic [NUM_PORTS-1:0]               readdatavalid;

  modport master (
    output address, writedata, byteenable, write, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, byteenable, write, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/ddr3_avl_arbiter.sv
// ddr3_avl_arbiter
// Shares the single Avalon-MM port of the DDR3 controller between
// NUM_MASTERS masters. Single-beat reads and writes are granted in
// round-robin order. Read responses return in order and are steered back
// to the issuing master through an ID FIFO.
//   clk, rstn          : clock and asynchronous active-low reset
//   m_if (slave)       : upstream masters, each in slice i of the buses
//   s_if (master)      : downstream DDR3 slave, with NUM_PORTS = 1
//   outstanding        : reads issued but not yet returned
//   err_unexpected_rdv : sticky; set when read data arrives and no read
//                        is outstanding
module ddr3_avl_arbiter #(
  parameter int NUM_MASTERS       = 2,
  parameter int AVL_ADDR_WIDTH    = 29,
  parameter int AVL_DATA_WIDTH    = 512,
  parameter int AVL_BYTE_EN_WIDTH = AVL_DATA_WIDTH / 8,
  parameter int MAX_OUTSTANDING   = 16,
  parameter int ID_WIDTH          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                              clk,
  input  logic                              rstn,
  ddr3_avl_arbiter_if.slave                 m_if,
  ddr3_avl_arbiter_if.master                s_if,
  output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
  output logic                              err_unexpected_rdv
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANTED = 1'b1} state_t;

  state_t                  state_r;
  logic [ID_WIDTH-1:0]     grant_id_r;
  logic [ID_WIDTH-1:0]     last_grant_r;
  logic [ID_WIDTH-1:0]     fifo_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic                    err_r;

  logic [NUM_MASTERS-1:0]       req_s;
  logic                         found_s;
  logic [ID_WIDTH-1:0]          next_grant_s;
  int                           idx_s;
  logic                         g_write_s;
  logic                         g_read_s;
  logic                         pop_s;
  logic                         can_push_s;
  logic                         push_s;
  logic                         accept_s;
  logic [AVL_ADDR_WIDTH-1:0]    s_addr_s;
  logic [AVL_DATA_WIDTH-1:0]    s_wdata_s;
  logic [AVL_BYTE_EN_WIDTH-1:0] s_be_s;
  logic                         s_write_s;
  logic                         s_read_s;
  logic [NUM_MASTERS-1:0]       m_wait_s;
  logic [NUM_MASTERS-1:0]       m_rdv_s;

  assign req_s     = m_if.write | m_if.read;
  assign g_write_s = m_if.write[grant_id_r];
  assign g_read_s  = m_if.read[grant_id_r];
  assign pop_s     = s_if.readdatavalid[0] && (count_r != CNT_W'(0));
  // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
  assign can_push_s = (count_r != CNT_W'(MAX_OUTSTANDING)) || pop_s;
  assign accept_s   = (s_write_s || s_read_s) && !s_if.waitrequest[0];
  assign push_s     = s_read_s && !s_if.waitrequest[0];

  // Round-robin search starting one past the last accepted master.
  always_comb begin
    found_s      = 1'b0;
    next_grant_s = '0;
    idx_s        = 0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx_s = (int'(last_grant_r) + k) % NUM_MASTERS;
      if (!found_s && req_s[idx_s]) begin
        found_s      = 1'b1;
        next_grant_s = ID_WIDTH'(idx_s);
      end else begin
        found_s      = found_s;
      end
    end
  end

  // Command path: the granted master's slice is presented to the slave.
  always_comb begin
    s_addr_s  = '0;
    s_wdata_s = '0;
    s_be_s    = '0;
    s_write_s = 1'b0;
    s_read_s  = 1'b0;
    m_wait_s  = '1;
    if (state_r == ST_GRANTED) begin
      s_addr_s  = m_if.address[grant_id_r*AVL_ADDR_WIDTH +: AVL_ADDR_WIDTH];
      s_wdata_s = m_if.writedata[grant_id_r*AVL_DATA_WIDTH +: AVL_DATA_WIDTH];
      s_be_s    = m_if.byteenable[grant_id_r*AVL_BYTE_EN_WIDTH +: AVL_BYTE_EN_WIDTH];
      if (g_write_s) begin
        s_write_s = 1'b1;
      end else if (g_read_s && can_push_s) begin
        s_read_s = 1'b1;
      end else begin
        s_write_s = 1'b0;
        s_read_s  = 1'b0;
      end
      // A read stalled on a full FIFO keeps its master waiting.
      if (s_write_s || s_read_s) begin
        m_wait_s[grant_id_r] = s_if.waitrequest[0];
      end else begin
        m_wait_s[grant_id_r] = 1'b1;
      end
    end else begin
      m_wait_s = '1;
    end
  end

  // Response steering: the FIFO head selects which master sees the data.
  always_comb begin
    m_rdv_s = '0;
    if (pop_s) begin
      m_rdv_s[fifo_mem_r[rd_ptr_r]] = 1'b1;
    end else begin
      m_rdv_s = '0;
    end
  end

  assign s_if.address     = s_addr_s;
  assign s_if.writedata   = s_wdata_s;
  assign s_if.byteenable  = s_be_s;
  assign s_if.write       = s_write_s;
  assign s_if.read        = s_read_s;
  assign m_if.waitrequest   = m_wait_s;
  assign m_if.readdata      = s_if.readdata;
  assign m_if.readdatavalid = m_rdv_s;
  assign outstanding        = count_r;
  assign err_unexpected_rdv = err_r;

  // Grant state machine.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= ST_IDLE;
      grant_id_r   <= '0;
      last_grant_r <= ID_WIDTH'(NUM_MASTERS - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            grant_id_r <= next_grant_s;
            state_r    <= ST_GRANTED;
          end
        end
        ST_GRANTED: begin
          if (accept_s) begin
            last_grant_r <= grant_id_r;
            state_r      <= ST_IDLE;
          end else if (!g_write_s && !g_read_s) begin
            // The master withdrew its request; keep the rotation unchanged.
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Read ID FIFO, occupancy count and the unexpected-response flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      err_r    <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= grant_id_r;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (s_if.readdatavalid[0] && (count_r == CNT_W'(0))) begin
        err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// tb_ddr3_avl_arbiter
// Directed bench for ddr3_avl_arbiter with two masters and a four-deep read
// ID FIFO. Inputs change 2 time units after a rising edge, and outputs are
// sampled 1 time unit later, well away from the next edge.
module tb_ddr3_avl_arbiter;
  localparam int NM = 2;
  localparam int AW = 29;
  localparam int DW = 512;
  localparam int BW = DW / 8;
  localparam int MO = 4;

  logic clk;
  logic rstn;
  logic [$clog2(MO):0] outstanding;
  logic err_unexpected_rdv;
  int n_cmp = 0;
  int n_bad = 0;

  ddr3_avl_arbiter_if #(.NUM_PORTS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_EN_WIDTH(BW)) m_bus ();
  ddr3_avl_arbiter_if #(.NUM_PORTS(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_EN_WIDTH(BW)) s_bus ();

  ddr3_avl_arbiter #(
    .NUM_MASTERS(NM), .AVL_ADDR_WIDTH(AW), .AVL_DATA_WIDTH(DW),
    .AVL_BYTE_EN_WIDTH(BW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rstn(rstn), .m_if(m_bus), .s_if(s_bus),
    .outstanding(outstanding), .err_unexpected_rdv(err_unexpected_rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    m_bus.address    = '0;
    m_bus.writedata  = '0;
    m_bus.byteenable = '0;
    m_bus.write      = 2'b00;
    m_bus.read       = 2'b00;
    s_bus.waitrequest   = 1'b0;
    s_bus.readdata      = '0;
    s_bus.readdatavalid = 1'b0;
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    #1;
    step();
    step();
    rstn = 1'b1;
  endtask

  // One single-beat command from master id, with the slave ready.
  task automatic issue(input int id, input bit wr, input logic [AW-1:0] addr);
    logic [1:0] expw;
    expw = 2'b11;
    expw[id] = 1'b0;
    step();
    m_bus.address[id*AW +: AW] = addr;
    if (wr) m_bus.write[id] = 1'b1;
    else    m_bus.read[id]  = 1'b1;
    #1;
    check("issue_idle", {s_bus.write, s_bus.read}, 2'b00);
    step();
    #1;
    check("issue_cmd", wr ? s_bus.write : s_bus.read, 1'b1);
    check("issue_addr", s_bus.address, addr);
    check("issue_wait", m_bus.waitrequest, expw);
    step();
    m_bus.write = 2'b00;
    m_bus.read  = 2'b00;
    #1;
  endtask

  initial begin
    logic [BW-1:0] be_all;
    logic [DW-1:0] d [3];
    logic [1:0]    exp_rdv4 [3];
    logic [1:0]    exp_rdv5 [4];
    int nwr;
    be_all = '1;
    d[0] = {64{8'hD0}};
    d[1] = {64{8'hD1}};
    d[2] = {64{8'hD2}};
    exp_rdv4[0] = 2'b01; exp_rdv4[1] = 2'b10; exp_rdv4[2] = 2'b01;
    exp_rdv5[0] = 2'b10; exp_rdv5[1] = 2'b01; exp_rdv5[2] = 2'b10; exp_rdv5[3] = 2'b01;

    // Reset values
    clear_inputs();
    rstn = 1'b1;
    #1;
    rstn = 1'b0;
    #2;
    check("rst_s_write", s_bus.write, 1'b0);
    check("rst_s_read", s_bus.read, 1'b0);
    check("rst_s_addr", s_bus.address, '0);
    check("rst_s_wdata", s_bus.writedata, '0);
    check("rst_m_wait", m_bus.waitrequest, 2'b11);
    check("rst_m_rdv", m_bus.readdatavalid, 2'b00);
    check("rst_outst", outstanding, 3'd0);
    check("rst_err", err_unexpected_rdv, 1'b0);
    step();
    step();
    rstn = 1'b1;

    // 1: single write from master 0
    m_bus.write = 2'b01;
    m_bus.address[0 +: AW] = 29'h10;
    m_bus.writedata[0 +: DW] = {64{8'hA5}};
    m_bus.byteenable[0 +: BW] = be_all;
    #1;
    check("t1_c0_write", s_bus.write, 1'b0);
    step();
    #1;
    check("t1_c1_write", s_bus.write, 1'b1);
    check("t1_c1_addr", s_bus.address, 29'h10);
    check("t1_c1_wdata", s_bus.writedata, {64{8'hA5}});
    check("t1_c1_be", s_bus.byteenable, be_all);
    check("t1_c1_wait", m_bus.waitrequest, 2'b10);
    step();
    m_bus.write = 2'b00;
    #1;
    check("t1_c2_write", s_bus.write, 1'b0);
    check("t1_c2_wait", m_bus.waitrequest, 2'b11);

    // 2: both masters write continuously; alternation 0,1,0,1
    clear_inputs();
    reset_dut();
    m_bus.address = {29'h200, 29'h100};
    m_bus.write = 2'b11;
    nwr = 0;
    #1;
    check("t2_c0_write", s_bus.write, 1'b0);
    for (int c = 1; c < 8; c++) begin
      step();
      #1;
      check("t2_write", s_bus.write, (c % 2 == 1) ? 1'b1 : 1'b0);
      if (s_bus.write) begin
        nwr++;
        check("t2_addr", s_bus.address, (c == 1 || c == 5) ? 29'h100 : 29'h200);
      end
    end
    check("t2_count", nwr, 4);

    // 3: master 1 write stalled three cycles, then master 0
    step();
    m_bus.write = 2'b10;
    s_bus.waitrequest = 1'b1;
    #1;
    check("t3_idle_write", s_bus.write, 1'b0);
    step();
    m_bus.write = 2'b11;
    #1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        step();
        #1;
      end
      check("t3_stall_write", s_bus.write, 1'b1);
      check("t3_stall_addr", s_bus.address, 29'h200);
      check("t3_stall_wait", m_bus.waitrequest, 2'b11);
    end
    step();
    s_bus.waitrequest = 1'b0;
    #1;
    check("t3_acc_wait", m_bus.waitrequest, 2'b01);
    check("t3_acc_addr", s_bus.address, 29'h200);
    step();
    m_bus.write = 2'b01;
    #1;
    check("t3_idle2_write", s_bus.write, 1'b0);
    step();
    #1;
    check("t3_m0_write", s_bus.write, 1'b1);
    check("t3_m0_addr", s_bus.address, 29'h100);
    check("t3_m0_wait", m_bus.waitrequest, 2'b10);
    step();
    m_bus.write = 2'b00;
    #1;

    // 4: three reads, in-order return
    issue(0, 1'b0, 29'h0A0);
    issue(1, 1'b0, 29'h0B0);
    issue(0, 1'b0, 29'h0C0);
    check("t4_outst3", outstanding, 3'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      s_bus.readdatavalid = 1'b1;
      s_bus.readdata = d[i];
      #1;
      check("t4_rdv", m_bus.readdatavalid, exp_rdv4[i]);
      check("t4_rdata", m_bus.readdata, d[i]);
      check("t4_outst", outstanding, 3'(3 - i));
    end
    step();
    s_bus.readdatavalid = 1'b0;
    #1;
    check("t4_outst0", outstanding, 3'd0);
    check("t4_rdv_idle", m_bus.readdatavalid, 2'b00);

    // 5: FIFO full stalls a fifth read until a response frees a slot
    issue(0, 1'b0, 29'h040);
    issue(1, 1'b0, 29'h041);
    issue(0, 1'b0, 29'h042);
    issue(1, 1'b0, 29'h043);
    check("t5_outst4", outstanding, 3'd4);
    step();
    m_bus.read = 2'b01;
    m_bus.address[0 +: AW] = 29'h044;
    #1;
    step();
    #1;
    check("t5_full_read", s_bus.read, 1'b0);
    check("t5_full_wait", m_bus.waitrequest, 2'b11);
    step();
    #1;
    check("t5_hold_read", s_bus.read, 1'b0);
    check("t5_hold_outst", outstanding, 3'd4);
    step();
    s_bus.readdatavalid = 1'b1;
    #1;
    check("t5_pop_rdv", m_bus.readdatavalid, 2'b01);
    check("t5_pop_read", s_bus.read, 1'b1);
    check("t5_pop_wait", m_bus.waitrequest, 2'b10);
    step();
    s_bus.readdatavalid = 1'b0;
    m_bus.read = 2'b00;
    #1;
    check("t5_pushpop_outst", outstanding, 3'd4);
    check("t5_after_read", s_bus.read, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      s_bus.readdatavalid = 1'b1;
      #1;
      check("t5_drain_rdv", m_bus.readdatavalid, exp_rdv5[i]);
    end
    step();
    s_bus.readdatavalid = 1'b0;
    #1;
    check("t5_outst0", outstanding, 3'd0);

    // 6: unexpected response, then reset mid-grant
    step();
    s_bus.readdatavalid = 1'b1;
    #1;
    check("t6_rdv_none", m_bus.readdatavalid, 2'b00);
    step();
    s_bus.readdatavalid = 1'b0;
    #1;
    check("t6_err_set", err_unexpected_rdv, 1'b1);
    step();
    #1;
    check("t6_err_held", err_unexpected_rdv, 1'b1);
    m_bus.write = 2'b01;
    m_bus.address[0 +: AW] = 29'h077;
    s_bus.waitrequest = 1'b1;
    step();
    #1;
    check("t6_granted", s_bus.write, 1'b1);
    rstn = 1'b0;
    #1;
    check("t6_rst_write", s_bus.write, 1'b0);
    check("t6_rst_addr", s_bus.address, '0);
    check("t6_rst_wait", m_bus.waitrequest, 2'b11);
    check("t6_rst_err", err_unexpected_rdv, 1'b0);
    check("t6_rst_outst", outstanding, 3'd0);
    m_bus.write = 2'b00;
    s_bus.waitrequest = 1'b0;
    step();
    rstn = 1'b1;
    step();
    s_bus.readdatavalid = 1'b1;
    #1;
    check("t6_post_rdv", m_bus.readdatavalid, 2'b00);
    step();
    s_bus.readdatavalid = 1'b0;
    #1;
    check("t6_post_err", err_unexpected_rdv, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
